// File: rtl/vga_timing_gen.sv
// VGA timing generator: walks a pixel/line raster one position per enabled
// strobe and produces sync, blanking, coordinates and frame/line events.
// Every output is a flop loaded from the decode of the next counter values, so
// each output describes the current position without extra latency or glitches.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10,
    parameter int FW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          strobe,
    input  logic          en,
    input  logic [CW-1:0] line_cmp,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          active,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          sol,
    output logic          sof,
    output logic          line_irq,
    output logic [FW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Refuse geometries whose counters cannot fit in CW bits or that have an
    // empty region (an empty region would make the region decodes ambiguous).
    if (H_TOTAL - 1 > 2**CW - 1 || V_TOTAL - 1 > 2**CW - 1) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: every H_*/V_* timing parameter must be non-zero");
    end

    // Region boundaries expressed at counter width.
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] X_MAX   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_MAX   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] xpos_q, xpos_d;
    logic [CW-1:0] ypos_q, ypos_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          sol_q, sol_d;
    logic          sof_q, sof_d;
    logic          line_irq_q, line_irq_d;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;

    // Next raster position, events, and output decode of that next position.
    always_comb begin
        tick        = strobe & en;
        h_wrap      = (hcnt_q == H_LAST);
        v_wrap      = (vcnt_q == V_LAST);
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        sol_d       = 1'b0;
        sof_d       = 1'b0;

        if (tick) begin
            if (h_wrap) begin
                hcnt_d = '0;
                sol_d  = 1'b1;
                if (v_wrap) begin
                    vcnt_d      = '0;
                    sof_d       = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        // vcnt_d never reaches V_TOTAL, so an out-of-range compare value
        // can never match.
        line_irq_d = sol_d && (vcnt_d == line_cmp);

        active_d = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        hsync_d  = (hcnt_d >= HS_BEG && hcnt_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = (vcnt_d >= VS_BEG && vcnt_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        xpos_d   = (hcnt_d < H_ACT) ? hcnt_d : X_MAX;
        ypos_d   = (vcnt_d < V_ACT) ? vcnt_d : Y_MAX;
    end

    // State and output registers; reset parks the raster at the first pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            active_q    <= 1'b1;
            sol_q       <= 1'b0;
            sof_q       <= 1'b0;
            line_irq_q  <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            sol_q       <= sol_d;
            sof_q       <= sof_d;
            line_irq_q  <= line_irq_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign active    = active_q;
    assign blank     = ~active_q;
    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign sol       = sol_q;
    assign sof       = sof_q;
    assign line_irq  = line_irq_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-raster
// instance with active-high hsync, both driven by the same strobe/en stream.
// A reference raster model pushes expected outputs into per-DUT queues at
// drive time; they are popped and compared one cycle later.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, strobe, en;
    logic [9:0] line_cmp0, line_cmp1;

    logic       hs0, vs0, bl0, ac0, sol0, sof0, irq0;
    logic [9:0] x0, y0;
    logic [7:0] fc0;
    logic       hs1, vs1, bl1, ac1, sol1, sof1, irq1;
    logic [9:0] x1, y1;
    logic [7:0] fc1;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .strobe(strobe), .en(en), .line_cmp(line_cmp0),
        .hsync(hs0), .vsync(vs0), .blank(bl0), .active(ac0),
        .xpos(x0), .ypos(y0), .sol(sol0), .sof(sof0), .line_irq(irq0),
        .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(10), .FW(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .strobe(strobe), .en(en), .line_cmp(line_cmp1),
        .hsync(hs1), .vsync(vs1), .blank(bl1), .active(ac1),
        .xpos(x1), .ypos(y1), .sol(sol1), .sof(sof1), .line_irq(irq1),
        .frame_cnt(fc1)
    );

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } tim_t;

    tim_t tim [2];
    int   mh [2], mv [2], mf [2];
    bit   ms [2], mso [2], mi [2];

    logic [34:0] sb0 [$];
    logic [34:0] sb1 [$];

    int n_cmp = 0;
    int n_bad = 0;

    int  en_hold = 0;
    bit  gap_armed = 0;
    int  tick_cnt = 0, hs_run = 0, irq_cnt = 0, sof_seen = 0, frame_cmp = 4;
    bit  have_sol = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] pack_obs(input int k);
        if (k == 0) return {hs0, vs0, ac0, bl0, x0, y0, sol0, sof0, irq0, fc0};
        return {hs1, vs1, ac1, bl1, x1, y1, sol1, sof1, irq1, fc1};
    endfunction

    // Expected output word for the model position of instance k.
    function automatic logic [34:0] expect_out(input int k);
        tim_t t = tim[k];
        int h = mh[k];
        int v = mv[k];
        logic act, hs, vs;
        int x, y;
        act = (h < t.ha) && (v < t.va);
        hs  = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.hp : !t.hp;
        vs  = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.vp : !t.vp;
        x   = (h < t.ha) ? h : t.ha - 1;
        y   = (v < t.va) ? v : t.va - 1;
        return {hs, vs, act, !act, 10'(x), 10'(y), ms[k], mso[k], mi[k], 8'(mf[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mv[k] = 0; mf[k] = 0;
            ms[k] = 0; mso[k] = 0; mi[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit tick, input int cmp);
        int ht = tim[k].ha + tim[k].hf + tim[k].hs + tim[k].hb;
        int vt = tim[k].va + tim[k].vf + tim[k].vs + tim[k].vb;
        ms[k] = 0; mso[k] = 0; mi[k] = 0;
        if (tick) begin
            if (mh[k] == ht - 1) begin
                mh[k] = 0;
                ms[k] = 1;
                if (mv[k] == vt - 1) begin
                    mv[k]  = 0;
                    mso[k] = 1;
                    mf[k]  = (mf[k] + 1) % 256;
                end else begin
                    mv[k] = mv[k] + 1;
                end
                mi[k] = (mv[k] == cmp);
            end else begin
                mh[k] = mh[k] + 1;
            end
        end
    endtask

    // One clock: drive at negedge, push expectations, compare after posedge.
    task automatic cycle(input bit gaps);
        bit tick;
        @(negedge clk);
        if (!rst) rst = 1'b1;
        strobe = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (gap_armed && mh[0] == 300) begin
            en_hold   = 50;
            gap_armed = 0;
        end
        en = (en_hold == 0);
        if (en_hold > 0) en_hold--;
        tick = strobe && en;
        model_step(0, tick, int'(line_cmp0));
        model_step(1, tick, int'(line_cmp1));
        sb0.push_back(expect_out(0));
        sb1.push_back(expect_out(1));

        @(posedge clk);
        #1;
        check_val("dut0", pack_obs(0), sb0.pop_front());
        check_val("dut1", pack_obs(1), sb1.pop_front());

        if (!en) check_val("xpos_hold", x0, 300);

        if (tick) begin
            tick_cnt++;
            if (!hs0) hs_run++;
            else if (hs_run > 0) begin
                check_val("hs_width", hs_run, 96);
                hs_run = 0;
            end
        end
        if (sol0) begin
            if (have_sol) check_val("sol_period", tick_cnt, 800);
            have_sol = 1;
            tick_cnt = 0;
        end

        if (irq1) irq_cnt++;
        if (sof1) begin
            check_val("irq_per_frame", irq_cnt, (frame_cmp == 4) ? 1 : 0);
            sof_seen++;
            if (sof_seen == 3) line_cmp1 = 10'd20;
            frame_cmp = int'(line_cmp1);
            irq_cnt   = 0;
        end
    endtask

    // Reset pulse between clock edges with strobe and en still high.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_val("rst_async0", pack_obs(0), expect_out(0));
        check_val("rst_async1", pack_obs(1), expect_out(1));
        @(posedge clk);
        #1;
        check_val("rst_hold0", pack_obs(0), expect_out(0));
        check_val("rst_hold1", pack_obs(1), expect_out(1));
        line_cmp1 = 10'd4;
        frame_cmp = 4;
        irq_cnt   = 0;
        hs_run    = 0;
        tick_cnt  = 0;
        have_sol  = 0;
    endtask

    initial begin
        tim[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        tim[1] = '{8, 2, 3, 2, 6, 2, 2, 3, 1'b1, 1'b0};
        rst = 1'b0;
        strobe = 1'b0;
        en = 1'b0;
        line_cmp0 = 10'd100;
        line_cmp1 = 10'd4;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hsync", hs0, 1);
        check_val("rst_vsync", vs0, 1);
        check_val("rst_active", ac0, 1);
        check_val("rst_xy", {x0, y0}, 0);
        check_val("rst_frame", fc0, 0);
        check_val("rst_state1", pack_obs(1), expect_out(1));

        // Back-to-back strobes over two full default lines.
        repeat (1700) cycle(1'b0);

        // Irregular strobes plus a 50-clock enable drop at xpos 300.
        line_cmp0 = 10'd600;
        gap_armed = 1;
        repeat (1800) cycle(1'b1);
        check_val("en_gap_seen", gap_armed, 0);

        mid_reset();
        repeat (700) cycle(1'b1);

        check_val("frames_seen", (sof_seen >= 8), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
